hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/wisc_hzd_pkg.sv | 22 ++
 rtl/hzd_match.sv | 44 ++++
 rtl/hazard_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/wisc_hzd_pkg.sv
// Shared types and widths for the hazard controller: FSM state encoding,
// stall counter width, register address width and statistics counter width.
package wisc_hzd_pkg;

    localparam int STALL_W    = 2;
    localparam int REG_ADDR_W = 3;
    localparam int STATS_W    = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FREEZE = 2'd2
    } hzd_state_e;

    function automatic logic [STALL_W-1:0] stall_max(
        input logic [STALL_W-1:0] a,
        input logic [STALL_W-1:0] b
    );
        stall_max = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hzd_match.sv
// Register address comparisons between the ID instruction and the producers
// sitting in EX and MEM; r0 is compared like any other register.
module hzd_match
    import wisc_hzd_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_mem_write,
    input  logic                  id_branch,
    input  logic                  id_jr_jalr,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  mem_reg_write,
    input  logic                  mem_mem_read,
    output logic                  load_use,
    output logic                  br_ex_alu,
    output logic                  br_ex_load,
    output logic                  br_mem_load
);

    logic rs_eq_ex;
    logic rt_eq_ex;
    logic rs_eq_mem;
    logic is_br;
    logic rt_read;

    assign rs_eq_ex  = (id_rs_addr == ex_rd_addr);
    assign rt_eq_ex  = (id_rt_addr == ex_rd_addr);
    assign rs_eq_mem = (id_rs_addr == mem_rd_addr);
    assign is_br     = id_branch | id_jr_jalr;
    // Stores read Rt as their data operand even when the decoder says no Rt use.
    assign rt_read   = id_uses_rt | id_mem_write;

    assign load_use    = ex_mem_read & ex_reg_write &
                         ((id_uses_rs & rs_eq_ex) | (rt_read & rt_eq_ex));
    assign br_ex_alu   = is_br & rs_eq_ex & ex_reg_write & ~ex_mem_read;
    assign br_ex_load  = is_br & rs_eq_ex & ex_reg_write & ex_mem_read;
    assign br_mem_load = is_br & rs_eq_mem & mem_mem_read & mem_reg_write;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble/flush/freeze FSM with a stall counter.
// Define HAZARD_STATS_EN to add saturating stall_cycles and flush_count outputs.
module hazard_ctrl
    import wisc_hzd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] ID_rs_addr,
    input  logic [REG_ADDR_W-1:0] ID_rt_addr,
    input  logic                  ID_uses_rs,
    input  logic                  ID_uses_rt,
    input  logic                  ID_mem_write,
    input  logic                  branch,
    input  logic                  JR_JALR,
    input  logic                  branch_taken,
    input  logic [REG_ADDR_W-1:0] EX_rd_addr,
    input  logic [REG_ADDR_W-1:0] MEM_rd_addr,
    input  logic                  EX_reg_write,
    input  logic                  EX_mem_read,
    input  logic                  MEM_reg_write,
    input  logic                  MEM_mem_read,
    input  logic                  mem_stall,
    output logic                  PC_hold,
    output logic                  IF_ID_hold,
    output logic                  ID_EX_bubble,
    output logic                  IF_ID_flush,
    output logic                  ID_EX_hold,
    output logic                  EX_MEM_hold,
`ifdef HAZARD_STATS_EN
    output logic [STATS_W-1:0]    stall_cycles,
    output logic [STATS_W-1:0]    flush_count,
`endif
    output logic [1:0]            hzd_state
);

    logic load_use;
    logic br_ex_alu;
    logic br_ex_load;
    logic br_mem_load;

    hzd_match u_match (
        .id_rs_addr   (ID_rs_addr),
        .id_rt_addr   (ID_rt_addr),
        .id_uses_rs   (ID_uses_rs),
        .id_uses_rt   (ID_uses_rt),
        .id_mem_write (ID_mem_write),
        .id_branch    (branch),
        .id_jr_jalr   (JR_JALR),
        .ex_rd_addr   (EX_rd_addr),
        .mem_rd_addr  (MEM_rd_addr),
        .ex_reg_write (EX_reg_write),
        .ex_mem_read  (EX_mem_read),
        .mem_reg_write(MEM_reg_write),
        .mem_mem_read (MEM_mem_read),
        .load_use     (load_use),
        .br_ex_alu    (br_ex_alu),
        .br_ex_load   (br_ex_load),
        .br_mem_load  (br_mem_load)
    );

    hzd_state_e         state_q, state_d;
    hzd_state_e         prev_state_q, prev_state_d;
    hzd_state_e         eff_state;
    logic [STALL_W-1:0] stall_left_q, stall_left_d;
    logic [STALL_W-1:0] need;
    logic [STALL_W-1:0] need_lu;
    logic [STALL_W-1:0] need_br_ex;
    logic [STALL_W-1:0] need_br_mem;

    always_comb begin
        need_lu     = load_use ? STALL_W'(1) : '0;
        need_br_ex  = br_ex_load ? STALL_W'(2) : (br_ex_alu ? STALL_W'(1) : '0);
        need_br_mem = br_mem_load ? STALL_W'(1) : '0;
        need        = stall_max(stall_max(need_lu, need_br_ex), need_br_mem);
    end

    // Leaving FREEZE takes effect in the same cycle mem_stall drops, so the held
    // ID instruction never slips past an unfinished stall.
    always_comb begin
        eff_state = state_q;
        if (state_q == ST_FREEZE) begin
            eff_state = (stall_left_q != '0) ? ST_STALL : prev_state_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        prev_state_d = prev_state_q;
        stall_left_d = stall_left_q;
        PC_hold      = 1'b0;
        IF_ID_hold   = 1'b0;
        ID_EX_bubble = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_hold   = 1'b0;
        EX_MEM_hold  = 1'b0;

        if (mem_stall) begin
            PC_hold     = 1'b1;
            IF_ID_hold  = 1'b1;
            ID_EX_hold  = 1'b1;
            EX_MEM_hold = 1'b1;
            state_d     = ST_FREEZE;
            if (state_q != ST_FREEZE) begin
                prev_state_d = state_q;
            end
        end else begin
            case (eff_state)
                ST_STALL: begin
                    PC_hold      = 1'b1;
                    IF_ID_hold   = 1'b1;
                    ID_EX_bubble = 1'b1;
                    if (stall_left_q <= STALL_W'(1)) begin
                        stall_left_d = '0;
                        state_d      = ST_RUN;
                    end else begin
                        stall_left_d = stall_left_q - STALL_W'(1);
                        state_d      = ST_STALL;
                    end
                end
                default: begin
                    if (need != '0) begin
                        PC_hold      = 1'b1;
                        IF_ID_hold   = 1'b1;
                        ID_EX_bubble = 1'b1;
                        stall_left_d = need - STALL_W'(1);
                        state_d      = (need > STALL_W'(1)) ? ST_STALL : ST_RUN;
                    end else begin
                        IF_ID_flush  = branch_taken;
                        stall_left_d = '0;
                        state_d      = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            prev_state_q <= ST_RUN;
            stall_left_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_state_q <= prev_state_d;
            stall_left_q <= stall_left_d;
        end
    end

    assign hzd_state = state_q;

`ifdef HAZARD_STATS_EN
    logic [STATS_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [STATS_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (ID_EX_bubble && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + STATS_W'(1);
        end
        if (IF_ID_flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + STATS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule
